// File: rtl/serial_link_credit_ctrl.sv
// ============================================================================
// Module   : serial_link_credit_ctrl
// Purpose  : Multi-VC credit flow control with round-robin send arbitration
//            and piggybacked / forced return-credit beats.
// Option   : define SERIAL_LINK_CREDIT_ERR_EN to build the sticky err_o logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_link_credit_ctrl #(
    parameter int NumVc           = 2,
    parameter int NumCredits      = 8,
    parameter int ForceSendThresh = NumCredits - 1,
    parameter int DataWidth       = 64,
    localparam int VcW            = (NumVc > 1) ? $clog2(NumVc) : 1,
    localparam int CW             = $clog2(NumCredits) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVc*DataWidth-1:0] data_i,
    input  logic [NumVc-1:0]           valid_i,
    output logic [NumVc-1:0]           ready_o,
    output logic [DataWidth-1:0]       data_o,
    output logic [VcW-1:0]             vc_o,
    output logic [CW-1:0]              credits_o,
    output logic                       credit_only_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    input  logic [CW-1:0]              credits_in_i,
    input  logic [VcW-1:0]             credits_in_vc_i,
    input  logic                       credits_in_valid_i,
    input  logic [NumVc-1:0]           buf_free_i,
    output logic [NumVc*CW-1:0]        send_cnt_o,
    output logic                       err_o
);

    localparam logic [CW-1:0] MAX_CRED = CW'(NumCredits);
    localparam logic [CW-1:0] THRESH   = CW'(ForceSendThresh);

    logic [NumVc-1:0][CW-1:0] send_cnt, send_nxt;
    logic [NumVc-1:0][CW-1:0] ret_cnt, ret_nxt;
    logic [VcW-1:0]           rr;

    logic             out_free, force_any, data_any, force_load, data_load;
    logic [VcW-1:0]   force_vc, grant;
    logic [NumVc-1:0] eligible;
`ifdef SERIAL_LINK_CREDIT_ERR_EN
    logic             err_set;
    logic             err_q;
`endif

    // Arbitration: forced credit return beats preempt data.
    always_comb begin : p_arb
        int idx;
        idx        = 0;
        out_free   = !valid_o || ready_i;
        force_any  = 1'b0;
        force_vc   = '0;
        data_any   = 1'b0;
        grant      = '0;
        eligible   = '0;
        for (int v = 0; v < NumVc; v++) begin
            if (!force_any && (ret_cnt[v] >= THRESH)) begin
                force_any = 1'b1;
                force_vc  = VcW'(v);
            end
            eligible[v] = valid_i[v] && (send_cnt[v] != '0);
        end
        for (int i = 0; i < NumVc; i++) begin
            idx = int'(rr) + i;
            if (idx >= NumVc) idx = idx - NumVc;
            if (!data_any && eligible[idx]) begin
                data_any = 1'b1;
                grant    = VcW'(idx);
            end
        end
        force_load = out_free && force_any;
        data_load  = out_free && !force_any && data_any;
        ready_o    = '0;
        if (data_load) ready_o[grant] = 1'b1;
    end

    always_comb begin : p_cnt
        logic          consume, add, clear;
        logic [CW:0]   sum;
        consume  = 1'b0;
        add      = 1'b0;
        clear    = 1'b0;
        sum      = '0;
        send_nxt = send_cnt;
        ret_nxt  = ret_cnt;
`ifdef SERIAL_LINK_CREDIT_ERR_EN
        err_set  = credits_in_valid_i && (32'(credits_in_vc_i) >= NumVc);
`endif
        for (int v = 0; v < NumVc; v++) begin
            consume = data_load && (grant == VcW'(v));
            add     = credits_in_valid_i && (credits_in_vc_i == VcW'(v));
            sum     = {1'b0, send_cnt[v]} + (add ? {1'b0, credits_in_i} : '0)
                      - {{CW{1'b0}}, consume};
            if (sum > {1'b0, MAX_CRED}) begin
                send_nxt[v] = MAX_CRED;
`ifdef SERIAL_LINK_CREDIT_ERR_EN
                err_set = 1'b1;
`endif
            end else begin
                send_nxt[v] = sum[CW-1:0];
            end

            // A free arriving on the clearing cycle is kept as the first new credit.
            clear = consume || (force_load && (force_vc == VcW'(v)));
            if (clear)
                ret_nxt[v] = buf_free_i[v] ? CW'(1) : '0;
            else if (buf_free_i[v] && (ret_cnt[v] != MAX_CRED))
                ret_nxt[v] = ret_cnt[v] + 1'b1;
`ifdef SERIAL_LINK_CREDIT_ERR_EN
            if (buf_free_i[v] && (ret_cnt[v] == MAX_CRED)) err_set = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < NumVc; v++) begin
                send_cnt[v] <= MAX_CRED;
                ret_cnt[v]  <= '0;
            end
            rr            <= '0;
            data_o        <= '0;
            vc_o          <= '0;
            credits_o     <= '0;
            credit_only_o <= 1'b0;
            valid_o       <= 1'b0;
        end else begin
            send_cnt <= send_nxt;
            ret_cnt  <= ret_nxt;
            if (force_load) begin
                data_o        <= '0;
                vc_o          <= force_vc;
                credits_o     <= ret_cnt[force_vc];
                credit_only_o <= 1'b1;
                valid_o       <= 1'b1;
            end else if (data_load) begin
                data_o        <= data_i[int'(grant)*DataWidth +: DataWidth];
                vc_o          <= grant;
                credits_o     <= ret_cnt[grant];
                credit_only_o <= 1'b0;
                valid_o       <= 1'b1;
                rr            <= (int'(grant) == NumVc - 1) ? '0 : grant + 1'b1;
            end else if (ready_i) begin
                valid_o       <= 1'b0;
            end
        end
    end

    for (genvar v = 0; v < NumVc; v++) begin : g_pack
        assign send_cnt_o[v*CW +: CW] = send_cnt[v];
    end

`ifdef SERIAL_LINK_CREDIT_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_link_credit_ctrl.sv
// ============================================================================
// Module   : tb_serial_link_credit_ctrl
// Purpose  : Directed self-checking bench for serial_link_credit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_link_credit_ctrl;

    localparam int DW = 64;
    localparam logic [DW-1:0] D0 = 64'hA0A0_0000_0000_00A0;
    localparam logic [DW-1:0] D1 = 64'hB1B1_0000_0000_00B1;
`ifdef SERIAL_LINK_CREDIT_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [127:0]  data_i;
    logic [1:0]    valid_i;
    logic [1:0]    ready_o;
    logic [63:0]   data_o;
    logic [0:0]    vc_o;
    logic [3:0]    credits_o;
    logic          credit_only_o;
    logic          valid_o;
    logic          ready_i;
    logic [3:0]    credits_in_i;
    logic [0:0]    credits_in_vc_i;
    logic          credits_in_valid_i;
    logic [1:0]    buf_free_i;
    logic [7:0]    send_cnt_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    serial_link_credit_ctrl dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .data_i             (data_i),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .data_o             (data_o),
        .vc_o               (vc_o),
        .credits_o          (credits_o),
        .credit_only_o      (credit_only_o),
        .valid_o            (valid_o),
        .ready_i            (ready_i),
        .credits_in_i       (credits_in_i),
        .credits_in_vc_i    (credits_in_vc_i),
        .credits_in_valid_i (credits_in_valid_i),
        .buf_free_i         (buf_free_i),
        .send_cnt_o         (send_cnt_o),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int beats, first, last;
        logic exp_vc;

        rst_ni = 1'b0; data_i = {D1, D0}; valid_i = '0; ready_i = 1'b0;
        credits_in_i = '0; credits_in_vc_i = '0; credits_in_valid_i = 1'b0; buf_free_i = '0;
        repeat (3) cyc();
        rst_ni = 1'b1;
        #1;
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_send_cnt", send_cnt_o, 8'h88);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_data", data_o, 0);

        // Both VCs streaming, no peer credits: 16 alternating beats back to back.
        valid_i = 2'b11; ready_i = 1'b1;
        beats = 0; first = 0; last = 0; exp_vc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (valid_o) begin
                if (beats == 0) first = k;
                last = k;
                check_eq("stream_vc", vc_o, exp_vc);
                check_eq("stream_data", data_o, exp_vc ? D1 : D0);
                exp_vc = ~exp_vc;
                beats++;
            end
        end
        check_eq("stream_beats", beats, 16);
        check_eq("stream_first", first, 1);
        check_eq("stream_last", last, 16);
        check_eq("stream_cnt", send_cnt_o, 8'h00);
        #1 check_eq("stream_ready", ready_o, 2'b00);

        // Peer returns 3 credits to VC0.
        credits_in_valid_i = 1'b1; credits_in_vc_i = 1'b0; credits_in_i = 4'd3;
        beats = 0; first = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 1) begin
                credits_in_valid_i = 1'b0;
                #1 check_eq("cred_ready", ready_o, 2'b01);
            end
            if (valid_o) begin
                if (beats == 0) first = k;
                check_eq("cred_vc", vc_o, 0);
                beats++;
            end
        end
        check_eq("cred_first", first, 2);
        check_eq("cred_beats", beats, 3);
        check_eq("cred_cnt", send_cnt_o, 8'h00);

        // Three frees on VC1 ride the next VC1 beat; a free on load cycle survives.
        valid_i = 2'b00;
        credits_in_valid_i = 1'b1; credits_in_vc_i = 1'b1; credits_in_i = 4'd1;
        buf_free_i = 2'b10;
        cyc();
        credits_in_valid_i = 1'b0;
        cyc();
        cyc();
        valid_i = 2'b10;
        #1 check_eq("ret_ready", ready_o, 2'b10);
        cyc();
        valid_i = 2'b00; buf_free_i = 2'b00;
        check_eq("ret_vc", vc_o, 1);
        check_eq("ret_credits", credits_o, 3);
        check_eq("ret_conly", credit_only_o, 0);
        check_eq("ret_data", data_o, D1);
        credits_in_valid_i = 1'b1; credits_in_vc_i = 1'b1; credits_in_i = 4'd1;
        cyc();
        credits_in_valid_i = 1'b0; valid_i = 2'b10;
        cyc();
        valid_i = 2'b00;
        check_eq("ret_keep", credits_o, 1);

        // Seven frees on VC0 force a credit-only beat ahead of VC1 data.
        credits_in_valid_i = 1'b1; credits_in_vc_i = 1'b1; credits_in_i = 4'd2;
        buf_free_i = 2'b01;
        cyc();
        credits_in_valid_i = 1'b0;
        repeat (6) cyc();
        buf_free_i = 2'b00; valid_i = 2'b10;
        #1 check_eq("force_ready", ready_o, 2'b00);
        cyc();
        check_eq("force_valid", valid_o, 1);
        check_eq("force_conly", credit_only_o, 1);
        check_eq("force_vc", vc_o, 0);
        check_eq("force_credits", credits_o, 7);
        check_eq("force_data", data_o, 0);
        check_eq("force_after", ready_o, 2'b10);
        cyc();
        check_eq("post_vc", vc_o, 1);
        check_eq("post_conly", credit_only_o, 0);
        check_eq("post_credits", credits_o, 0);

        // Stall with a VC1 beat pending, then reset in the middle of it.
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_eq("stall_valid", valid_o, 1);
            check_eq("stall_data", data_o, D1);
            check_eq("stall_vc", vc_o, 1);
            check_eq("stall_credits", credits_o, 0);
            check_eq("stall_cnt", send_cnt_o, 8'h10);
            check_eq("stall_ready", ready_o, 2'b00);
        end
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_cnt", send_cnt_o, 8'h88);
        cyc();
        rst_ni = 1'b1; valid_i = 2'b00; ready_i = 1'b1;

        // Peer over-returns to a full VC.
        credits_in_valid_i = 1'b1; credits_in_vc_i = 1'b0; credits_in_i = 4'd1;
        cyc();
        credits_in_valid_i = 1'b0;
        check_eq("ovf_cnt", send_cnt_o, 8'h88);
        check_eq("ovf_err", err_o, EXP_ERR);
        repeat (3) cyc();
        check_eq("ovf_err_hold", err_o, EXP_ERR);
        rst_ni = 1'b0;
        #1 check_eq("ovf_err_rst", err_o, 0);
        cyc();
        rst_ni = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_link_credit_ctrl.md
# serial_link_credit_ctrl

Multi-virtual-channel credit-based flow-control stage for the serial link data path, sitting between the AXI channel packers and the PHY framing logic. It generalises the single-pool credit scheme to `NumVc` independent virtual channels. Each channel has its own send-credit counter and return-credit counter, and a round-robin arbiter chooses which channel sends. Pending return credits ride on outgoing beats of the same VC; a standalone credit-only beat is forced when a return count reaches a threshold.

## Interface
- `NumVc`, 2: number of virtual channels, >=1; `VcW = max(1,$clog2(NumVc))`.
- `NumCredits`, 8: credits per VC, >=2; `CW = $clog2(NumCredits)+1`.
- `ForceSendThresh`, `NumCredits-1`: return count that forces a credit-only beat, 1..`NumCredits`.
- `DataWidth`, 64: payload width.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `data_i`, in, `NumVc*DataWidth`: per-VC payload; VC v occupies `[v*DataWidth +: DataWidth]`.
- `valid_i`, in, `NumVc`: per-VC payload valid.
- `ready_o`, out, `NumVc`: per-VC accept, one-hot or zero.
- `data_o`, out, `DataWidth`: outgoing payload; zero on credit-only beats.
- `vc_o`, out, `VcW`: VC of the outgoing beat.
- `credits_o`, out, `CW`: return credits piggybacked for `vc_o`.
- `credit_only_o`, out, 1: beat carries credits only.
- `valid_o`, out, 1 / `ready_i`, in, 1: output handshake.
- `credits_in_i`, in, `CW` / `credits_in_vc_i`, in, `VcW` / `credits_in_valid_i`, in, 1: credits returned by the peer.
- `buf_free_i`, in, `NumVc`: local receive buffer of VC v released one entry this cycle.
- `send_cnt_o`, out, `NumVc*CW`: current send credits, for debug.
- `err_o`, out, 1: sticky credit error (see Configuration).

## Operation
- State:
  - `send_cnt[v]`: reset `NumCredits`.
  - `ret_cnt[v]`: reset 0.
  - Output register holding `data_o`, `vc_o`, `credits_o`, `credit_only_o`, `valid_o`: all reset 0.
  - Round-robin pointer `rr`: reset 0.
- Output register is free when `!valid_o || ready_i`. A load happens only when the register is free.
- Force mode: active when any `ret_cnt[v] >= ForceSendThresh`. It has priority over data. It loads a credit-only beat for the lowest such v with `credits_o = ret_cnt[v]` and `data_o = 0`, and all `ready_o = 0` that cycle.
- Data mode:
  - VC v is eligible when `valid_i[v] && send_cnt[v] != 0`.
  - The grant goes to the first eligible VC at or after `rr`, wrapping modulo `NumVc`. Only the granted VC sees `ready_o[v] = 1`.
  - On load: `send_cnt[v]` decrements, `credits_o = ret_cnt[v]`, `ret_cnt[v]` clears, and `rr` moves to v+1, wrapping.
- Return counting: `buf_free_i[v]` increments `ret_cnt[v]`. If the same cycle also clears `ret_cnt[v]`, the new value is 1 (the free is not lost). The counter saturates at `NumCredits`.
- Peer credits: when `credits_in_valid_i` is high, `send_cnt[credits_in_vc_i] += credits_in_i`. With a simultaneous consume, the net result is `+credits_in_i-1`. The result saturates at `NumCredits`.
- A beat is held stable while `valid_o && !ready_i`.

## Timing
- Input accept to `valid_o`: 1 cycle. Full throughput is 1 beat per cycle when `ready_i` is held high.
- `ready_o` is combinational from `valid_i`, the counters, `valid_o` and `ready_i`. There is no combinational path from `valid_i` to `valid_o`.
- Counter updates from `credits_in_*` and `buf_free_i` are visible the next cycle. A VC whose `send_cnt` is 0 becomes eligible one cycle after credits arrive.
- When `send_cnt[v]` reaches 0, v is blocked starting the next cycle. Other VCs are unaffected.
- Reset assertion mid-transfer: all state returns immediately to reset values, and an in-flight beat is dropped.

## Configuration
- `SERIAL_LINK_CREDIT_ERR_EN` defined: `err_o` is set and held until reset when any of these occur:
  - a peer credit update would exceed `NumCredits`;
  - `buf_free_i[v]` arrives while `ret_cnt[v] == NumCredits`;
  - `credits_in_vc_i >= NumVc`.
- `SERIAL_LINK_CREDIT_ERR_EN` undefined: `err_o` is tied to 0 and no error logic is built. Saturation behaviour is identical in both builds; an out-of-range `credits_in_vc_i` is ignored.

## Test plan
- Reset, then `valid_i=2'b11` for 20 cycles with `ready_i=1` and no peer credits: 16 beats go out, alternating VC 0,1,0,1; `send_cnt_o` ends at 0/0 and `ready_o` stays 0 afterwards.
- With VC0 exhausted, apply `credits_in_valid_i=1`, `vc=0`, `credits=3`: exactly 3 more VC0 beats, the first appearing 2 cycles after the credit cycle.
- Pulse `buf_free_i[1]` 3 times, then send one VC1 beat: `credits_o=3`, `credit_only_o=0`, and `ret_cnt[1]` returns to 0. A `buf_free_i[1]` on the load cycle leaves `ret_cnt[1]` at 1.
- Pulse `buf_free_i[0]` 7 times with `ForceSendThresh=7` and `valid_i[1]` held: the next load is credit-only with `vc_o=0`, `credits_o=7`, `data_o=0`, and `ready_o[1]=0` during that cycle.
- Hold `ready_i=0` for 5 cycles with a beat pending: `data_o`, `vc_o` and `credits_o` stay stable and `send_cnt_o` does not change. Assert `rst_ni=0` mid-stall: `valid_o=0` and counters return to 8.
- With the macro defined, send `credits_in_i=1` to a full VC: `err_o=1`, `send_cnt` stays 8, and `err_o` remains set until reset. With the macro undefined, `err_o=0`.
